fp_mul_pipe: RTL and testbench

Three-stage pipelined multiplier that produces the products consumed by the downstream FP32/fixed-point adder in the MAC datapath. It accepts operand pairs on a valid/ready handshake and returns one product per cycle at full throughput. It matches the adder's number conventions: canonical NaN 0x7FC00000, truncation rounding, flush-to-zero on underflow, and saturation in fixed-point mode.

---
 rtl/fp_mul_pipe_if.sv | 28 ++
 rtl/fp_mul_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand/product handshake bundle for fp_mul_pipe.
//   in_valid/in_ready/in_a/in_b/in_last : operand pair channel (master -> slave)
//   out_valid/out_ready/out_p/out_last  : product channel (slave -> master)
// The multiplier connects to the slave modport; the producer/consumer side
// uses the master modport.
interface fp_mul_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;
    logic             out_last;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_p, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_p, out_last
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined multiplier (FP32 or signed fixed point).
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (clears valids and output registers)
//   bus  : fp_mul_pipe_if.slave -- operand pairs in, products out, with an
//          in_last tag carried alongside each pair.
// FP32 mode: canonical NaN 0x7FC00000, truncation, flush-to-zero, denormal
// inputs read as zero. Fixed mode: Q(INT_BITS).(FRAC_BITS), floor shift,
// saturation to the signed WIDTH range.
// The whole pipe advances together whenever the output register is empty
// or being drained; otherwise every stage holds.
module fp_mul_pipe #(
    parameter     FORMAT    = "FP32",
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16,
    parameter int WIDTH     = 32
) (
    input  logic         clk,
    input  logic         rst,
    fp_mul_pipe_if.slave bus
);
    localparam bit IS_FP = (FORMAT == "FP32");
    localparam int FXW   = INT_BITS + FRAC_BITS;

    if (IS_FP && WIDTH != 32) begin : g_bad_fp_width
        $error("fp_mul_pipe: WIDTH must be 32 in FP32 mode");
    end
    if (!IS_FP && FXW != WIDTH) begin : g_bad_fx_width
        $error("fp_mul_pipe: WIDTH must equal INT_BITS+FRAC_BITS in fixed mode");
    end

    logic             adv;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic             last1_q, last1_d, last2_q, last2_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_p_q, out_p_d;
    logic [WIDTH-1:0] result3;     // stage-3 combinational product

    // A bubble at the output never blocks the pipe.
    assign adv           = !v3_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_last  = out_last_q;

    always_comb begin
        v1_d       = adv ? bus.in_valid : v1_q;
        v2_d       = adv ? v1_q         : v2_q;
        v3_d       = adv ? v2_q         : v3_q;
        last1_d    = adv ? bus.in_last  : last1_q;
        last2_d    = adv ? last1_q      : last2_q;
        out_last_d = adv ? last2_q      : out_last_q;
        out_p_d    = adv ? result3      : out_p_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            out_p_q    <= '0;
            out_last_q <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            out_p_q    <= out_p_d;
            out_last_q <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        last1_q <= last1_d;
        last2_q <= last2_d;
    end

    if (IS_FP) begin : g_fp
        localparam logic [31:0] QNAN = 32'h7FC0_0000;

        logic              sign1_q, sign1_d, sign2_q, sign2_d;
        logic signed [9:0] exp1_q, exp1_d, exp2_q, exp2_d;
        logic [23:0]       ma1_q, ma1_d, mb1_q, mb1_d;
        logic              spec1_q, spec1_d, spec2_q, spec2_d;
        logic [31:0]       sres1_q, sres1_d, sres2_q, sres2_d;
        logic [47:0]       prod2_q, prod2_d;

        logic [7:0]        a_exp, b_exp;
        logic [22:0]       a_man, b_man;
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;
        logic              spec_hit;
        logic [31:0]       spec_res;
        logic signed [9:0] e_n;
        logic [22:0]       mant;
        logic              unused_prod_bits;

        // Stage 1: unpack and classify. exp==0 (denormals too) reads as zero.
        always_comb begin
            a_exp  = bus.in_a[30:23];
            b_exp  = bus.in_b[30:23];
            a_man  = bus.in_a[22:0];
            b_man  = bus.in_b[22:0];
            s      = bus.in_a[31] ^ bus.in_b[31];
            a_zero = (a_exp == 8'h00);
            b_zero = (b_exp == 8'h00);
            a_inf  = (a_exp == 8'hFF) && (a_man == 23'd0);
            b_inf  = (b_exp == 8'hFF) && (b_man == 23'd0);
            a_nan  = (a_exp == 8'hFF) && (a_man != 23'd0);
            b_nan  = (b_exp == 8'hFF) && (b_man != 23'd0);

            spec_hit = 1'b1;
            spec_res = 32'd0;
            if (a_nan || b_nan)
                spec_res = QNAN;
            else if ((a_inf && b_zero) || (b_inf && a_zero))
                spec_res = QNAN;
            else if (a_inf || b_inf)
                spec_res = {s, 8'hFF, 23'd0};
            else if (a_zero || b_zero)
                spec_res = {s, 31'd0};
            else
                spec_hit = 1'b0;

            sign1_d = adv ? s : sign1_q;
            exp1_d  = adv ? ($signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127)
                          : exp1_q;
            ma1_d   = adv ? {1'b1, a_man} : ma1_q;
            mb1_d   = adv ? {1'b1, b_man} : mb1_q;
            spec1_d = adv ? spec_hit : spec1_q;
            sres1_d = adv ? spec_res : sres1_q;
        end

        // Stage 2: full 24x24 mantissa product.
        always_comb begin
            sign2_d = adv ? sign1_q : sign2_q;
            exp2_d  = adv ? exp1_q  : exp2_q;
            spec2_d = adv ? spec1_q : spec2_q;
            sres2_d = adv ? sres1_q : sres2_q;
            prod2_d = adv ? (48'(ma1_q) * 48'(mb1_q)) : prod2_q;
        end

        // Stage 3: one-bit normalize, truncate, overflow to inf, flush to zero.
        always_comb begin
            if (prod2_q[47]) begin
                mant = prod2_q[46:24];
                e_n  = exp2_q + 10'sd1;
            end else begin
                mant = prod2_q[45:23];
                e_n  = exp2_q;
            end
            if (spec2_q)
                result3 = sres2_q;
            else if (e_n >= 10'sd255)
                result3 = {sign2_q, 8'hFF, 23'd0};
            else if (e_n <= 10'sd0)
                result3 = {sign2_q, 31'd0};
            else
                result3 = {sign2_q, e_n[7:0], mant};
        end

        // Bits below the truncation point never reach the result.
        assign unused_prod_bits = ^prod2_q[22:0];

        always_ff @(posedge clk) begin
            sign1_q <= sign1_d;
            exp1_q  <= exp1_d;
            ma1_q   <= ma1_d;
            mb1_q   <= mb1_d;
            spec1_q <= spec1_d;
            sres1_q <= sres1_d;
            sign2_q <= sign2_d;
            exp2_q  <= exp2_d;
            spec2_q <= spec2_d;
            sres2_q <= sres2_d;
            prod2_q <= prod2_d;
        end
    end else begin : g_fx
        localparam int PW = 2 * FXW;
        localparam logic signed [PW-1:0] MAX_W = $signed({{(FXW+1){1'b0}}, {(FXW-1){1'b1}}});
        localparam logic signed [PW-1:0] MIN_W = $signed({{(FXW+1){1'b1}}, {(FXW-1){1'b0}}});

        logic signed [FXW-1:0] a1_q, a1_d, b1_q, b1_d;
        logic signed [PW-1:0]  prod2_q, prod2_d;
        logic signed [PW-1:0]  shifted;

        always_comb begin
            a1_d    = adv ? $signed(bus.in_a[FXW-1:0]) : a1_q;
            b1_d    = adv ? $signed(bus.in_b[FXW-1:0]) : b1_q;
            prod2_d = adv ? ($signed(PW'(a1_q)) * $signed(PW'(b1_q))) : prod2_q;
        end

        // Arithmetic shift floors toward -inf; then clamp to the signed range.
        always_comb begin
            shifted = prod2_q >>> FRAC_BITS;
            if (shifted > MAX_W)
                result3 = MAX_W[FXW-1:0];
            else if (shifted < MIN_W)
                result3 = MIN_W[FXW-1:0];
            else
                result3 = shifted[FXW-1:0];
        end

        always_ff @(posedge clk) begin
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            prod2_q <= prod2_d;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed, self-checking bench for fp_mul_pipe.
// One FP32 instance and one Q16.16 instance; each transaction prints a line.
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.WIDTH(32)) fp_bus ();
    fp_mul_pipe_if #(.WIDTH(32)) fx_bus ();

    fp_mul_pipe #(.FORMAT("FP32"), .INT_BITS(16), .FRAC_BITS(16), .WIDTH(32)) u_fp (
        .clk (clk),
        .rst (rst),
        .bus (fp_bus.slave)
    );

    fp_mul_pipe #(.FORMAT("FIXED"), .INT_BITS(16), .FRAC_BITS(16), .WIDTH(32)) u_fx (
        .clk (clk),
        .rst (rst),
        .bus (fx_bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit fx, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic last, input logic ordy);
        if (fx) begin
            fx_bus.in_valid = v; fx_bus.in_a = a; fx_bus.in_b = b;
            fx_bus.in_last = last; fx_bus.out_ready = ordy;
        end else begin
            fp_bus.in_valid = v; fp_bus.in_a = a; fp_bus.in_b = b;
            fp_bus.in_last = last; fp_bus.out_ready = ordy;
        end
    endtask

    task automatic sample(input bit fx, output logic ov, output logic [31:0] p,
                          output logic ol, output logic ir);
        if (fx) begin
            ov = fx_bus.out_valid; p = fx_bus.out_p; ol = fx_bus.out_last; ir = fx_bus.in_ready;
        end else begin
            ov = fp_bus.out_valid; p = fp_bus.out_p; ol = fp_bus.out_last; ir = fp_bus.in_ready;
        end
    endtask

    // Present one pair, capture at the next edge, expect the product valid
    // after the third edge counted from the launch (capture + 2).
    task automatic single(input bit fx, input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic last);
        logic ov, ol, ir;
        logic [31:0] p;
        @(negedge clk);
        drive(fx, 1'b1, a, b, last, 1'b1);
        #1 sample(fx, ov, p, ol, ir);
        check({tag, ".in_ready"}, 32'(ir), 32'd1);
        @(posedge clk);
        #1 drive(fx, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        sample(fx, ov, p, ol, ir);
        check({tag, ".lat1"}, 32'(ov), 32'd0);
        @(posedge clk);
        #1 sample(fx, ov, p, ol, ir);
        check({tag, ".lat2"}, 32'(ov), 32'd0);
        @(posedge clk);
        #1 sample(fx, ov, p, ol, ir);
        check({tag, ".valid"}, 32'(ov), 32'd1);
        check({tag, ".p"}, p, exp);
        check({tag, ".last"}, 32'(ol), 32'(last));
        $display("%s %s a=%08h b=%08h p=%08h exp=%08h", fx ? "FIX" : "FP ", tag, a, b, p, exp);
    endtask

    logic [31:0] st_a   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] st_exp [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

    initial begin
        logic ov, ol, ir, ordy, stalled;
        logic [31:0] p, held;
        int sent, rcv;

        rst = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            sample(d[0], ov, p, ol, ir);
            check("reset.out_valid", 32'(ov), 32'd0);
            check("reset.out_p", p, 32'd0);
            check("reset.out_last", 32'(ol), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1 sample(0, ov, p, ol, ir);
        check("reset.in_ready", 32'(ir), 32'd1);
        $display("RESET done out_valid=%0d in_ready=%0d", ov, ir);

        // FP32 basic, boundaries and specials.
        single(0, "fp_1.5x2",    32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);
        single(0, "fp_-1x3",     32'hBF800000, 32'h40400000, 32'hC0400000, 1'b1);
        single(0, "fp_ovf",      32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0);
        single(0, "fp_unf",      32'h00800000, 32'h00800000, 32'h00000000, 1'b0);
        single(0, "fp_denorm",   32'h00400000, 32'h3F800000, 32'h00000000, 1'b0);
        single(0, "fp_negzero",  32'h80000000, 32'h3F800000, 32'h80000000, 1'b0);
        single(0, "fp_nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
        single(0, "fp_infxzero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0);
        single(0, "fp_-infx2",   32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0);

        // Fixed Q16.16.
        single(1, "fx_1.5x2",    32'h00018000, 32'h00020000, 32'h00030000, 1'b0);
        single(1, "fx_-0.5x2",   32'hFFFF8000, 32'h00020000, 32'hFFFF0000, 1'b1);
        single(1, "fx_satpos",   32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b0);
        single(1, "fx_satneg",   32'h80000000, 32'h00020000, 32'h80000000, 1'b0);

        // Backpressure stream: out_ready pattern 1,0,0 repeating.
        sent = 0; rcv = 0; stalled = 1'b0; held = 32'd0;
        for (int cyc = 0; cyc < 200 && rcv < 8; cyc++) begin
            @(negedge clk);
            sample(0, ov, p, ol, ir);
            if (stalled) check("stream.stall_hold", p, held);
            ordy = ((cyc % 3) == 0);
            if (sent < 8) drive(0, 1'b1, st_a[sent], 32'h40000000, sent == 7, ordy);
            else          drive(0, 1'b0, 32'd0, 32'd0, 1'b0, ordy);
            #1 sample(0, ov, p, ol, ir);
            check("stream.in_ready", 32'(ir), 32'(!ov || ordy));
            if (ov && ordy) begin
                check("stream.p", p, st_exp[rcv]);
                check("stream.last", 32'(ol), 32'(rcv == 7));
                $display("STREAM rx#%0d p=%08h exp=%08h last=%0d", rcv, p, st_exp[rcv], ol);
                rcv++;
            end
            if (sent < 8 && ir) sent++;
            stalled = ov && !ordy;
            held = p;
        end
        check("stream.count", 32'(rcv), 32'd8);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            sample(0, ov, p, ol, ir);
            check("stream.no_dup", 32'(ov), 32'd0);
        end

        // Reset with three pairs in flight.
        @(negedge clk);
        drive(0, 1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b1);
        @(posedge clk); #1 drive(0, 1'b1, 32'h40400000, 32'h40000000, 1'b0, 1'b1);
        @(posedge clk); #1 drive(0, 1'b1, 32'h40800000, 32'h40000000, 1'b1, 1'b1);
        @(posedge clk); #1 drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sample(0, ov, p, ol, ir);
        check("midrst.out_valid", 32'(ov), 32'd0);
        check("midrst.out_p", p, 32'd0);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1 sample(0, ov, p, ol, ir);
            check("midrst.no_stale", 32'(ov), 32'd0);
        end
        $display("MIDRST flushed out_valid=%0d", ov);
        single(0, "fp_post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
